// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle divide controller for the execute stage.
// Runs a 32-iteration restoring shift-subtract division for DIV/DIVU and
// returns {remainder, quotient} for the HI/LO write path.
//
// Ports:
//   clk           pipeline clock, rising-edge
//   rst           asynchronous active-low reset
//   start_i       divide request, held by ex until the result is consumed
//   signed_div_i  1 = DIV (signed), 0 = DIVU; sampled on acceptance
//   opdata1_i     dividend; sampled on acceptance
//   opdata2_i     divisor; sampled on acceptance
//   annul_i       cancel from an execute-stage flush or exception
//   result_o      registered {remainder, quotient}
//   ready_o       registered result-valid
//   busy_o        high in DIVZERO/ON, decoded from the state register only
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StDivZero,
        StOn,
        StEnd
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [64:0] w_q, w_d;
    logic [31:0] divisor_q, divisor_d;
    logic        sign_quo_q, sign_quo_d;
    logic        sign_rem_q, sign_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    // Operand magnitudes for the acceptance edge.
    logic [31:0] mag1, mag2;
    // One restoring iteration on the current working register.
    logic [64:0] shifted;
    logic [32:0] diff;
    logic [64:0] iter_w;
    logic [31:0] rem, quo;

    always_comb begin
        mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

        shifted = w_q << 1;
        diff    = shifted[64:32] - {1'b0, divisor_q};
        // A borrow (diff[32]) means the divisor did not fit: keep the plain shift.
        iter_w  = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};
        rem     = iter_w[63:32];
        quo     = iter_w[31:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        divisor_d  = divisor_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = StDivZero;
                    end else begin
                        state_d    = StOn;
                        divisor_d  = mag2;
                        sign_quo_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        sign_rem_d = signed_div_i & opdata1_i[31];
                        cnt_d      = 5'd0;
                        w_d        = {33'b0, mag1};
                    end
                end
            end
            StDivZero: begin
                // HI/LO are architecturally unpredictable here; defined as zero.
                result_d = 64'd0;
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    state_d = StEnd;
                    ready_d = 1'b1;
                end
            end
            StOn: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    w_d   = iter_w;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = {sign_rem_q ? -rem : rem, sign_quo_q ? -quo : quo};
                        ready_d  = 1'b1;
                        state_d  = StEnd;
                    end
                end
            end
            StEnd: begin
                if (!start_i || annul_i) begin
                    state_d  = StIdle;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            w_q        <= 65'd0;
            divisor_q  <= 32'd0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            divisor_q  <= divisor_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q == StDivZero) || (state_q == StOn);

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and random stimulus for div_ctrl, checked against an
// arithmetic model of DIV/DIVU built on 64-bit truncating division.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int total;
    int bad;

    div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: quotient truncates toward zero, remainder takes the dividend's
    // sign; 64-bit intermediates avoid the 0x80000000 / -1 overflow.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge with it idle.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        int          lat;
        int          nbusy;
        exp          = ref_div(sgn, a, b);
        start_i      = 1'b1;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        @(posedge clk);
        lat   = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy_o === 1'b1) nbusy++;
        end while (ready_o !== 1'b1 && lat < 100);
        chk({tag, " ready"}, 64'(ready_o), 64'd1);
        chk({tag, " latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        chk({tag, " busy_cycles"}, 64'(nbusy), (b == 32'd0) ? 64'd1 : 64'd32);
        chk({tag, " result"}, result_o, exp);
        // Operands are ignored once accepted; result holds while start is high.
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom);
        @(negedge clk);
        chk({tag, " hold"}, {ready_o, busy_o, result_o}, {1'b1, 1'b0, exp});
        start_i = 1'b0;
        @(negedge clk);
        chk({tag, " release"}, {ready_o, busy_o, result_o}, 66'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          seen_ready;

        total        = 0;
        bad          = 0;
        rst          = 1'b0;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        annul_i      = 1'b0;
        #1;
        chk("reset outputs", {ready_o, busy_o, result_o}, 66'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle after reset", {ready_o, busy_o, result_o}, 66'd0);

        run_op("divu 100/7", 1'b0, 32'd100, 32'd7);
        chk("divu 100/7 model", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("div 5/0", 1'b1, 32'd5, 32'd0);
        run_op("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1);

        // Cancel on the 10th ON cycle.
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        @(posedge clk);
        repeat (10) @(negedge clk);
        chk("cancel busy before", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        @(negedge clk);
        chk("cancel idle", {ready_o, busy_o, result_o}, 66'd0);
        annul_i    = 1'b0;
        start_i    = 1'b0;
        seen_ready = 0;
        repeat (30) begin
            @(negedge clk);
            if (ready_o === 1'b1 || busy_o === 1'b1) seen_ready++;
        end
        chk("cancel stays idle", 64'(seen_ready), 64'd0);
        run_op("divu 9/3 after cancel", 1'b0, 32'd9, 32'd3);

        // Annul while in DIVZERO.
        start_i   = 1'b1;
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        @(posedge clk);
        @(negedge clk);
        chk("divzero busy", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        @(negedge clk);
        chk("divzero annul", {ready_o, busy_o, result_o}, 66'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);

        // start_i dropped during ON: the divide still completes, then END falls through.
        start_i      = 1'b1;
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFF_FF9C;
        opdata2_i    = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (32) @(negedge clk);
        chk("drop start result", {ready_o, busy_o, result_o},
            {1'b1, 1'b0, ref_div(1'b1, 32'hFFFF_FF9C, 32'd3)});
        @(negedge clk);
        chk("drop start release", {ready_o, busy_o, result_o}, 66'd0);

        // Reset mid-ON.
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'hFFFF_FFFF;
        opdata2_i    = 32'd3;
        @(posedge clk);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        start_i = 1'b0;
        #1;
        chk("reset mid-on", {ready_o, busy_o, result_o}, 66'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("after reset idle", {ready_o, busy_o, result_o}, 66'd0);
        run_op("divu after reset", 1'b0, 32'd123456, 32'd789);

        // Reset while a result is being held.
        start_i      = 1'b1;
        signed_div_i = 1'b1;
        opdata1_i    = 32'd77;
        opdata2_i    = 32'hFFFF_FFF6;
        @(posedge clk);
        repeat (33) @(negedge clk);
        chk("pre-reset result", {ready_o, result_o},
            {1'b1, ref_div(1'b1, 32'd77, 32'hFFFF_FFF6)});
        #2 rst = 1'b0;
        start_i = 1'b0;
        #1;
        chk("reset in end", {ready_o, busy_o, result_o}, 66'd0);
        #1 rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'hFFFF_FFFF - $urandom_range(0, 7);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 50);
            run_op($sformatf("rand%0d", i), rs, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide controller for the execute stage. It accepts DIV/DIVU operands from ex, runs a 32-iteration restoring shift-subtract division, and returns a 64-bit {remainder, quotient} result for the HI/LO write path. It also raises a busy indication that ex turns into a pipeline stall request. It runs in the main pipeline clock domain, alongside ex.

## Interface
- No parameters. Data width is fixed at 32 bits.
- `clk`  in  1  pipeline clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  divide request. Held high by ex until the result is consumed.
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU (unsigned). Sampled only when a request is accepted.
- `opdata1_i`  in  32  dividend. Sampled only when a request is accepted.
- `opdata2_i`  in  32  divisor. Sampled only when a request is accepted.
- `annul_i`  in  1  cancel. Flush or exception in the execute stage.
- `result_o`  out  64  [63:32] = remainder (goes to HI), [31:0] = quotient (goes to LO). Registered.
- `ready_o`  out  1  result valid. Registered.
- `busy_o`  out  1  high while state is DIVZERO or ON. Combinational decode of the state register.

## Operation
- FSM states: IDLE, DIVZERO, ON, END. Reset (`rst` = 0) forces all of the following immediately, without waiting for a clock edge:
  - state = IDLE
  - cnt = 0
  - internal registers = 0
  - result_o = 0, ready_o = 0
- **IDLE**
  - Accepts a request on an edge where start_i = 1 and annul_i = 0.
  - If opdata2_i == 0, go to DIVZERO.
  - Otherwise go to ON and latch the following:
    - Operand magnitudes. When signed_div_i = 1, each negative operand is replaced by its two's complement (~x+1). When signed_div_i = 0, operands are latched unchanged.
    - sign_q = signed & (op1[31] ^ op2[31]).
    - sign_r = signed & op1[31].
    - cnt = 0.
    - 65-bit working register W = {33'b0, |op1|}.
- **DIVZERO**
  - On the next edge: result_o = 0, go to END.
  - MIPS leaves HI/LO unpredictable in this case; the team defines them as 0.
- **ON**, one iteration per edge:
  - Shift W left by 1.
  - Trial difference: d = W[64:32] − {1'b0, |op2|}.
  - If d is non-negative (d[32] = 0): W[64:32] = d and W[0] = 1. Otherwise W is left shifted only.
  - cnt = cnt + 1.
  - On the edge where cnt == 31:
    - Do the final iteration.
    - Load result_o = {sign_r ? −rem : rem, sign_q ? −quo : quo}, where rem = the post-iteration W[63:32] and quo = the post-iteration W[31:0].
    - Set ready_o = 1 and go to END.
  - annul_i = 1 on any ON edge: go to IDLE, ready_o stays 0, and result_o is not updated.
- **END**
  - ready_o = 1 and result_o is held while start_i = 1.
  - On an edge with start_i = 0 or annul_i = 1: go to IDLE, ready_o = 0, result_o = 0.
  - A new request is accepted only from IDLE. There is no back-to-back acceptance out of END.
- Arithmetic rules:
  - The subtractor is 33 bits wide.
  - All negation is two's complement modulo 2^32.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- annul_i in DIVZERO: go to IDLE with result 0.
- start_i falling in ON or DIVZERO without annul_i: ignored. The operation completes, and END then falls through to IDLE on the next edge.

## Timing
- Acceptance edge E0: IDLE → ON, and busy_o goes high in the cycle after E0.
- Iterations run on edges E1…E32. E32 is the edge where cnt == 31.
- ready_o and result_o are valid in the cycle after E32: a latency of 33 cycles from E0. busy_o is low in that cycle.
- Divide-by-zero: E0 → DIVZERO, E1 → END, so ready_o is high in the cycle after E1 (2 cycles).
- ex must hold start_i high while busy_o or ready_o is high. ex samples result_o in the first ready_o cycle and then drops start_i. The next edge returns the block to IDLE with ready_o = 0.
- No combinational path from any input to result_o or ready_o. busy_o depends only on the state register.

## Test plan
- **Unsigned divide:** DIVU 100 / 7, start held.
  - Expect busy_o high for 32 cycles, then ready_o high 33 cycles after acceptance.
  - Expect result_o = {32'd2, 32'd14}.
  - Drop start_i: next cycle ready_o = 0, result_o = 0.
- **Signed with sign correction:**
  - DIV −7 / 2 → result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
  - DIV 7 / −2 → result_o = {0x00000001, 0xFFFFFFFD}.
- **Divide by zero:** DIV 5 / 0 → ready_o high 2 cycles after acceptance, result_o = 0, busy_o high for exactly 1 cycle.
- **Overflow corner:** DIV 0x80000000 / 0xFFFFFFFF → result_o = {0x00000000, 0x80000000}. DIVU of the same operands → {0x80000000, 0x00000000}.
- **Cancel:** annul_i pulsed on the 10th ON cycle → state back to IDLE the next cycle, ready_o never asserts. A fresh DIVU 9 / 3 issued afterwards → {0, 3} after 33 cycles.
- **Reset mid-operation:** rst low for part of a cycle during ON → all outputs 0 immediately. After release, a new request completes with correct timing.
